// File: rtl/mult_pkg.sv
// Shared types and helpers for the signed shift-add multiplier.
// Sign extension goes through a fixed-width helper, so WIDTH is limited to MULT_SEXT_MAX.
package mult_pkg;

  localparam int MULT_WIDTH_DEFAULT = 8;
  localparam int MULT_SEXT_MAX      = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COMPUTE = 2'd1,
    HOLD    = 2'd2
  } mult_state_e;

  // Sign-extends the low w bits of v by one bit; callers cast the result down to w+1 bits.
  function automatic logic [MULT_SEXT_MAX:0] sext(input logic [MULT_SEXT_MAX-1:0] v,
                                                  input int w);
    logic [MULT_SEXT_MAX:0] r;
    logic                   sgn;
    sgn = 1'b0;
    for (int i = 0; i < MULT_SEXT_MAX; i++) begin
      if (i == w - 1) sgn = v[i];
    end
    for (int i = 0; i < MULT_SEXT_MAX; i++) begin
      r[i] = (i < w) ? v[i] : sgn;
    end
    r[MULT_SEXT_MAX] = sgn;
    return r;
  endfunction

endpackage

// File: rtl/adder_sub_n.sv
// Combinational WIDTH-bit adder/subtractor; subtraction is a + ~b + 1, wrap-around, no carry out.
module adder_sub_n #(
  parameter int WIDTH = 9
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  output logic [WIDTH-1:0] sum
);

  // Invert b and inject the carry-in when subtracting
  always_comb begin
    sum = a + (b ^ {WIDTH{sub}}) + WIDTH'(sub);
  end

endmodule

// File: rtl/multiplier_n.sv
// Signed WIDTH x WIDTH sequential multiplier, one add/subtract-and-shift step per clock.
// Optional feature macro: MULT_OVERFLOW_EN adds a registered 'overflow' output.
module multiplier_n
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH_DEFAULT
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               run,
  input  logic               clear_A_load_B,
  input  logic [WIDTH-1:0]   S,
  output logic [2*WIDTH-1:0] product,
  output logic               X,
  output logic               done
`ifdef MULT_OVERFLOW_EN
  ,
  output logic               overflow
`endif
);

  localparam int CW  = $clog2(WIDTH + 1);
  localparam int WP1 = WIDTH + 1;
  localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

  mult_state_e      state_q, state_d;
  logic             x_q, x_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [CW-1:0]    count_q, count_d;

  logic             last_step;
  logic [WIDTH:0]   a_ext;
  logic [WIDTH:0]   s_ext;
  logic [WIDTH:0]   sum;
  logic [WIDTH:0]   step_val;

`ifdef MULT_OVERFLOW_EN
  logic               overflow_q, overflow_d;
  logic [2*WIDTH-1:0] product_d;
  logic [WIDTH:0]     top_bits;
`endif

  assign last_step = (count_q == LAST_STEP);

  // Widen both operands so the accumulator sum carries its own sign bit into X
  always_comb begin
    a_ext = WP1'(sext(MULT_SEXT_MAX'(a_q), WIDTH));
    s_ext = WP1'(sext(MULT_SEXT_MAX'(S), WIDTH));
  end

  // The final step subtracts because B's top bit carries negative weight
  adder_sub_n #(
    .WIDTH(WIDTH + 1)
  ) u_adder (
    .a  (a_ext),
    .b  (s_ext),
    .sub(last_step),
    .sum(sum)
  );

  // State and datapath registers; reset abandons any multiply in flight
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      x_q     <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      count_q <= '0;
`ifdef MULT_OVERFLOW_EN
      overflow_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      a_q     <= a_d;
      b_q     <= b_d;
      count_q <= count_d;
`ifdef MULT_OVERFLOW_EN
      overflow_q <= overflow_d;
`endif
    end
  end

  // Next state: load has priority over run, and HOLD waits for run to drop
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (!clear_A_load_B && run) state_d = COMPUTE;
      end
      COMPUTE: begin
        if (last_step) state_d = HOLD;
      end
      HOLD: begin
        if (!run) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: load/clear in IDLE, conditional add then arithmetic shift of {X,A,B} in COMPUTE
  always_comb begin
    x_d      = x_q;
    a_d      = a_q;
    b_d      = b_q;
    count_d  = count_q;
    step_val = b_q[0] ? sum : {x_q, a_q};
    case (state_q)
      IDLE: begin
        if (clear_A_load_B) begin
          x_d = 1'b0;
          a_d = '0;
          b_d = S;
        end else if (run) begin
          x_d     = 1'b0;
          a_d     = '0;
          count_d = '0;
        end
      end
      COMPUTE: begin
        x_d     = step_val[WIDTH];
        a_d     = step_val[WIDTH:1];
        b_d     = {step_val[0], b_q[WIDTH-1:1]};
        count_d = count_q + CW'(1);
      end
      default: ;
    endcase
  end

`ifdef MULT_OVERFLOW_EN
  // Overflow is latched on the final step when the product does not fit in WIDTH signed bits
  always_comb begin
    overflow_d = overflow_q;
    product_d  = {a_d, b_d};
    top_bits   = product_d[2*WIDTH-1:WIDTH-1];
    if (state_q == IDLE && !clear_A_load_B && run) begin
      overflow_d = 1'b0;
    end else if (state_q == COMPUTE && last_step) begin
      overflow_d = !((&top_bits) || !(|top_bits));
    end
  end
`endif

  // Outputs come straight from registers
  always_comb begin
    product = {a_q, b_q};
    X       = x_q;
    done    = (state_q == HOLD);
`ifdef MULT_OVERFLOW_EN
    overflow = overflow_q;
`endif
  end

endmodule

// File: tb/tb_multiplier_n.sv
// Scoreboard bench for multiplier_n: stimulus pushes expected results, monitors pop on done.
// Builds with or without MULT_OVERFLOW_EN; overflow is checked only when the port exists.
module tb_multiplier_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        run8, clr8;
  logic [7:0]  s8;
  logic [15:0] product8;
  logic        x8, done8;
  logic        run16, clr16;
  logic [15:0] s16;
  logic [31:0] product16;
  logic        x16, done16;
`ifdef MULT_OVERFLOW_EN
  logic        ovf8, ovf16;
`endif

  typedef struct {
    logic [31:0] prod;
    logic        x;
    logic        ovf;
    int          edge_at;
    string       name;
  } exp_t;

  exp_t q8[$];
  exp_t q16[$];
  exp_t e8, e16;
  int   vectors     = 0;
  int   miscompares = 0;
  int   edge_cnt    = 0;
  logic done8_prev  = 1'b0;
  logic done16_prev = 1'b0;

  always #5 clk = ~clk;

  // Count rising edges so completion latency can be checked
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  multiplier_n #(.WIDTH(8)) dut8 (
    .clk           (clk),
    .reset         (reset),
    .run           (run8),
    .clear_A_load_B(clr8),
    .S             (s8),
    .product       (product8),
    .X             (x8),
    .done          (done8)
`ifdef MULT_OVERFLOW_EN
    ,
    .overflow      (ovf8)
`endif
  );

  multiplier_n #(.WIDTH(16)) dut16 (
    .clk           (clk),
    .reset         (reset),
    .run           (run16),
    .clear_A_load_B(clr16),
    .S             (s16),
    .product       (product16),
    .X             (x16),
    .done          (done16)
`ifdef MULT_OVERFLOW_EN
    ,
    .overflow      (ovf16)
`endif
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic clr_v, input logic run_v, input logic [7:0] s_v);
    clr8 = clr_v;
    run8 = run_v;
    s8   = s_v;
  endtask

  // Monitor for the 8-bit instance: every rising done consumes one expected result
  always @(negedge clk) begin
    if (done8 && !done8_prev) begin
      if (q8.size() == 0) begin
        checkOutput("unexpected done8", 32'(done8), 32'(1'b0));
      end else begin
        e8 = q8.pop_front();
        checkOutput({e8.name, " product"}, 32'(product8), e8.prod);
        checkOutput({e8.name, " X"}, 32'(x8), 32'(e8.x));
        checkOutput({e8.name, " done edge"}, 32'(edge_cnt), 32'(e8.edge_at));
`ifdef MULT_OVERFLOW_EN
        checkOutput({e8.name, " overflow"}, 32'(ovf8), 32'(e8.ovf));
`endif
      end
    end
    done8_prev = done8;
  end

  // Monitor for the 16-bit instance
  always @(negedge clk) begin
    if (done16 && !done16_prev) begin
      if (q16.size() == 0) begin
        checkOutput("unexpected done16", 32'(done16), 32'(1'b0));
      end else begin
        e16 = q16.pop_front();
        checkOutput({e16.name, " product"}, product16, e16.prod);
        checkOutput({e16.name, " X"}, 32'(x16), 32'(e16.x));
        checkOutput({e16.name, " done edge"}, 32'(edge_cnt), 32'(e16.edge_at));
`ifdef MULT_OVERFLOW_EN
        checkOutput({e16.name, " overflow"}, 32'(ovf16), 32'(e16.ovf));
`endif
      end
    end
    done16_prev = done16;
  end

  task automatic waitDone8(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q8.size() == 0) break;
      @(negedge clk);
    end
    if (q8.size() != 0) begin
      checkOutput("timeout waiting for done8", 32'(q8.size()), 32'd0);
      q8.delete();
    end
  endtask

  task automatic waitDone16(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (q16.size() == 0) break;
      @(negedge clk);
    end
    if (q16.size() != 0) begin
      checkOutput("timeout waiting for done16", 32'(q16.size()), 32'd0);
      q16.delete();
    end
  endtask

  // Called at a negedge: raise run with multiplicand s and queue the expected outcome
  task automatic startRun8(input string name, input logic [7:0] s, input logic [15:0] p,
                           input logic x, input logic o);
    exp_t e;
    applyStimulus(1'b0, 1'b1, s);
    e.prod    = 32'(p);
    e.x       = x;
    e.ovf     = o;
    e.edge_at = edge_cnt + 1 + 8;
    e.name    = name;
    q8.push_back(e);
  endtask

  task automatic multiply8(input string name, input logic [7:0] b, input logic [7:0] s,
                           input logic [15:0] p, input logic x, input logic o);
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, b);
    @(negedge clk);
    checkOutput({name, " load B"}, 32'(product8), 32'(b));
    startRun8(name, s, p, x, o);
    waitDone8(20);
    applyStimulus(1'b0, 1'b0, s);
    @(negedge clk);
    checkOutput({name, " done after run drop"}, 32'(done8), 32'd0);
  endtask

  initial begin
    exp_t e;
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00);
    run16 = 1'b0;
    clr16 = 1'b0;
    s16   = 16'h0000;
    repeat (3) @(negedge clk);
    checkOutput("reset product8", 32'(product8), 32'd0);
    checkOutput("reset done8", 32'(done8), 32'd0);
    checkOutput("reset X8", 32'(x8), 32'd0);
    checkOutput("reset product16", product16, 32'd0);
    reset = 1'b0;

    multiply8("ff_x_ff", 8'hFF, 8'hFF, 16'h0001, 1'b0, 1'b0);
    multiply8("07_x_fd", 8'h07, 8'hFD, 16'hFFEB, 1'b1, 1'b0);
    multiply8("80_x_80", 8'h80, 8'h80, 16'h4000, 1'b0, 1'b1);

    // Consecutive runs reuse the low half as the next multiplier
    @(negedge clk);
    applyStimulus(1'b1, 1'b0, 8'h7F);
    @(negedge clk);
    startRun8("7f_x_7f", 8'h7F, 16'h3F01, 1'b0, 1'b1);
    waitDone8(20);
    repeat (5) @(negedge clk);
    checkOutput("hold with run high done", 32'(done8), 32'd1);
    checkOutput("hold with run high product", 32'(product8), 32'h3F01);
    applyStimulus(1'b0, 1'b0, 8'h7F);
    @(negedge clk);
    checkOutput("idle after run drop done", 32'(done8), 32'd0);
    checkOutput("idle keeps product", 32'(product8), 32'h3F01);
    startRun8("01_x_ff", 8'hFF, 16'hFFFF, 1'b1, 1'b0);
    waitDone8(20);
    applyStimulus(1'b0, 1'b0, 8'hFF);
    @(negedge clk);

    // Reset sampled on the fourth compute step aborts the multiply
    applyStimulus(1'b1, 1'b0, 8'h55);
    @(negedge clk);
    applyStimulus(1'b0, 1'b1, 8'h03);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h03);
    @(negedge clk);
    reset = 1'b0;
    checkOutput("mid-compute reset product", 32'(product8), 32'd0);
    checkOutput("mid-compute reset done", 32'(done8), 32'd0);
    checkOutput("mid-compute reset X", 32'(x8), 32'd0);
    repeat (10) @(negedge clk);
    checkOutput("no completion after abort", 32'(done8), 32'd0);

    // Load and run together: load wins, multiply starts the edge after
    applyStimulus(1'b1, 1'b1, 8'h05);
    @(negedge clk);
    checkOutput("load+run loads B", 32'(product8), 32'h0005);
    checkOutput("load+run stays idle", 32'(done8), 32'd0);
    startRun8("05_x_03", 8'h03, 16'h000F, 1'b0, 1'b0);
    waitDone8(20);
    applyStimulus(1'b0, 1'b0, 8'h03);
    @(negedge clk);

    // 16-bit instance
    clr16 = 1'b1;
    s16   = 16'h8000;
    @(negedge clk);
    checkOutput("w16 load B", product16, 32'h0000_8000);
    clr16     = 1'b0;
    run16     = 1'b1;
    s16       = 16'h0003;
    e.prod    = 32'hFFFE_8000;
    e.x       = 1'b1;
    e.ovf     = 1'b1;
    e.edge_at = edge_cnt + 1 + 16;
    e.name    = "w16_8000_x_0003";
    q16.push_back(e);
    waitDone16(30);
    run16 = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("w16 done after run drop", 32'(done16), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/multiplier_n.md
# multiplier_n

Parametrised signed sequential multiplier: the WIDTH-generic successor to the fixed 8-bit shift-add multiplier, with a `done` handshake and synchronous reset. It computes a two's-complement WIDTH×WIDTH product with one add/subtract-and-shift step per clock. The switch/board top-level drives it: S supplies both operands, `clear_A_load_B` loads the multiplier, and `run` starts a computation.

## Interface
- WIDTH, 8, operand width in bits (≥2); product is 2·WIDTH bits
- clk  input  1  system clock; all state changes on its rising edge
- reset  input  1  synchronous, active-high; overrides every other input
- run  input  1  level; starts a multiply from IDLE; must drop before the next multiply can start
- clear_A_load_B  input  1  level; in IDLE sets A←0, X←0, B←S
- S  input  WIDTH  multiplicand during compute, B value during load
- product  output  2·WIDTH  {A,B}
- X  output  1  sign-extension bit of A (debug)
- done  output  1  high in HOLD
- overflow  output  1  present only with MULT_OVERFLOW_EN

## Operation
- Registers: X (1), A (WIDTH), B (WIDTH), count ($clog2(WIDTH+1)), state.
- States: IDLE, COMPUTE, HOLD.
- IDLE:
  - clear_A_load_B=1: A←0, X←0, B←S; stay IDLE. Takes priority over run in the same cycle.
  - Otherwise run=1: A←0, X←0, count←0, → COMPUTE. B is kept, so consecutive runs multiply the previous low half by the new S.
- COMPUTE, each edge:
  - If B[0]=1, {X,A} ← sext(A) + sext(S) when count<WIDTH−1, and sext(A) − sext(S) when count=WIDTH−1. Arithmetic is WIDTH+1 bits, wrap-around, no carry out.
  - The add result then shifts arithmetically right one place as {X,A,B} ← {X', X', A', B[WIDTH−1:1]}, all in the same edge.
  - count++. After the edge where count=WIDTH−1, → HOLD.
- HOLD: registers frozen, done=1. When run=0, → IDLE. clear_A_load_B is ignored until back in IDLE.
- clear_A_load_B and S changes during COMPUTE are ignored or undefined as follows:
  - clear_A_load_B is ignored.
  - S must be held stable; results are unspecified otherwise.
- Reset (any state, including mid-COMPUTE) aborts the operation: state=IDLE, X=0, A=0, B=0, count=0, so product=0, done=0, overflow=0.

## Timing
- Load: B is visible on product[WIDTH−1:0] one edge after clear_A_load_B is sampled.
- Multiply:
  - Edge 0 samples run in IDLE and clears A.
  - Edges 1..WIDTH each perform one step.
  - done rises after edge WIDTH, so the product is valid WIDTH+1 cycles after run is first sampled.
- run held high indefinitely yields exactly one multiply.
- run low for ≥1 cycle in HOLD returns to IDLE on that edge. The next run=1 in IDLE starts a new multiply the following edge.
- Outputs are registered only; there is no combinational path from inputs to outputs.

## Configuration
- MULT_OVERFLOW_EN defined:
  - The `overflow` output exists. It is registered and updates on the final COMPUTE edge.
  - It is 1 iff product is not the sign extension of product[WIDTH−1:0], i.e. the result does not fit in WIDTH signed bits.
  - It holds its value in HOLD and clears on reset or on leaving IDLE for COMPUTE.
- MULT_OVERFLOW_EN undefined: no `overflow` port and no related logic; all other behaviour is identical.

## Structure
- mult_pkg holds:
  - the state enum (IDLE, COMPUTE, HOLD);
  - the sext helper function;
  - the default-width constant MULT_WIDTH_DEFAULT=8.
- Sub-module adder_sub_n #(WIDTH+1): combinational (WIDTH+1)-bit add/subtract, with inputs a, b, sub and output sum; subtract is implemented as a + ~b + 1.
- multiplier_n contains the FSM, counter and X/A/B registers, and instantiates one adder_sub_n.

## Test plan
- WIDTH=8:
  - Load S=8'hFF, then run with S=8'hFF → product=16'h0001, X=0, done high at cycle 9 after run.
  - Load 8'h07, run with S=8'hFD (7×−3) → product=16'hFFEB.
  - Load 8'h80, run with S=8'h80 (−128×−128) → product=16'h4000; checks X handling on the final subtract.
  - Consecutive runs: load 8'h7F, run S=8'h7F → 16'h3F01. Drop run, run again with S=8'hFF (uses B=8'h01) → 16'hFFFF. Holding run high in HOLD must not retrigger.
- Reset asserted at COMPUTE step 4 → next cycle state IDLE, product=0, done=0. Assert clear_A_load_B and run together in IDLE → load only, multiply starts one cycle later.
- WIDTH=16: load 16'h8000, run S=16'h0003 → product=32'hFFFE8000.
- With MULT_OVERFLOW_EN: the 0x7F×0x7F case gives overflow=1; the 0xFF×0xFF case gives overflow=0.
